uart_rx: RTL
============

# uart_rx

UART receiver, 8N1, LSB first, 16x oversampled; receive-side counterpart of the team's UART transmitter, with matching CLK_FREQ/BAUD_RATE parameters. Sits between the asynchronous serial input pin and the fabric. It delivers each received byte on a valid/ready handshake and flags framing errors and overruns.

## Interface
- CLK_FREQ, 50_000_000: clk frequency in Hz
- BAUD_RATE, 57600: line bit rate
- localparam TICK_DIV = CLK_FREQ/(BAUD_RATE*16): clk cycles per oversample tick; must be ≥1
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- rx  input  1  serial line, asynchronous, idles high
- data  output  8  received byte, stable while valid=1
- valid  output  1  byte available
- ready  input  1  consumer accepts byte when valid&ready
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: byte completed while valid still 1
- busy  output  1  high in START/DATA/STOP/WAIT_IDLE

## Operation
- rx passes through a 2-flop synchronizer (flops reset to 1); all logic uses synchronized value rxs.
- Tick counter (16-bit) counts 0..TICK_DIV-1 and emits a tick at wrap. It is held at 0 in IDLE.
- Sample counter s_cnt is 4 bits and advances on each tick. It is zeroed on start detection and wraps 15→0 at each bit boundary.
- States:
  - IDLE: a 1→0 transition on rxs enters START and zeroes both counters.
  - START: at the decision tick, rxs=1 means a false start → IDLE. Otherwise go to DATA, bit index = 0.
  - DATA: at each decision tick, shift the sampled bit into bit[index], LSB first. After index 7, go to STOP.
  - STOP, sample 1: load data, set valid, go to IDLE. If valid was already 1: pulse overrun, keep the old data, drop the new byte.
  - STOP, sample 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1, then go to IDLE. A held break yields exactly one frame_err.
- Decision tick is the tick on which s_cnt==8 (see Configuration).
- Handshake: valid is cleared on any clk edge where valid&ready=1. ready while valid=0 is ignored. data is unchanged until the next accepted byte loads.
- When clearing valid coincides with a new byte loading in STOP, the load wins: valid stays 1 with the new data and there is no overrun.
- Returning to IDLE at mid-stop-bit allows a back-to-back start edge immediately.

## Timing
- Reset: data=0x00, valid=0, frame_err=0, overrun=0, busy=0, state=IDLE. Reset mid-frame aborts the frame with no output pulses.
- Latency from rx pin edge to falling-edge detection: 2–3 clk (synchronizer).
- Bit period = 16*TICK_DIV clk. The decision for bit n occurs 16*n+8 (or +9) ticks after start detection.
- valid, frame_err and overrun assert on the clk edge following the stop-bit decision tick. The pulses are exactly 1 clk wide.
- busy rises on the clk after start detection. It falls together with the valid/frame_err assertion, or on exit from WAIT_IDLE.

## Configuration
- UART_RX_MAJORITY_EN defined: samples taken at s_cnt 7, 8 and 9; bit value = majority of three; decision tick is s_cnt==9. Rejects single-tick glitches.
- Not defined: a single sample at s_cnt==8 is the bit value; decision tick is s_cnt==8.
- The state sequence and handshake are identical in both builds.

## Test plan
Bench uses CLK_FREQ=1_600_000, BAUD_RATE=10_000, so TICK_DIV=10 and 160 clk/bit.
- Frame 0xA5 sent, ready=1 -> valid for 1 clk with data=0xA5; no error pulses; busy low afterward.
- Back-to-back 0x00 then 0xFF with no idle gap, ready=1 -> two valid events, data 0x00 then 0xFF.
- rx low for 30 clk then high -> no valid and no frame_err; busy returns low within 16*10 clk.
- Frame 0x3C with stop=0, then 5 bit-times of low -> single frame_err pulse, valid stays 0; next good 0x55 is received.
- ready=0, send 0x11 then 0x22 -> valid=1, data=0x11, one overrun pulse; ready=1 for 1 clk -> valid=0.
- Macro defined, 10-clk high glitch at the center of bit 3 of 0x00 -> data=0x00. rst_n pulsed mid-byte -> outputs at reset values; next frame received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, LSB first, byte out on valid/ready.
// Optional UART_RX_MAJORITY_EN: 3-sample majority vote at s_cnt 7/8/9 instead of a single sample at 8.
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 57600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int          TICK_DIV  = CLK_FREQ / (BAUD_RATE * 16);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t      state, state_n;
  logic        rx_meta, rxs, rxs_d;
  logic [15:0] tick_cnt;
  logic [3:0]  s_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tick, decide, bit_val;
  logic        clr_cnt, shift, load, fe_set, ovr_set;

  assign tick = (state != IDLE) && (tick_cnt == TICK_LAST);

`ifdef UART_RX_MAJORITY_EN
  // Decision lands on the tick that advances s_cnt to 9; the two earlier
  // samples are captured on the ticks that advance it to 7 and 8.
  logic [1:0] smp;
  assign decide  = tick && (s_cnt == 4'd8);
  assign bit_val = (smp[1] & smp[0]) | (smp[1] & rxs) | (smp[0] & rxs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      smp <= 2'b11;
    else if (tick && (s_cnt == 4'd6 || s_cnt == 4'd7))
      smp <= {smp[0], rxs};
  end
`else
  assign decide  = tick && (s_cnt == 4'd7);
  assign bit_val = rxs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    clr_cnt = 1'b0;
    shift   = 1'b0;
    load    = 1'b0;
    fe_set  = 1'b0;
    ovr_set = 1'b0;
    case (state)
      IDLE: begin
        if (rxs_d && !rxs) begin
          state_n = START;
          clr_cnt = 1'b1;
        end
      end
      START: begin
        if (decide) state_n = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          shift = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (bit_val) begin
            state_n = IDLE;
            // A same-cycle accept frees the slot, so the new byte still loads.
            if (valid && !ready) ovr_set = 1'b1;
            else                 load    = 1'b1;
          end else begin
            fe_set  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      s_cnt     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (state == IDLE || clr_cnt || tick) tick_cnt <= '0;
      else                                  tick_cnt <= tick_cnt + 16'd1;

      if (clr_cnt)   s_cnt <= '0;
      else if (tick) s_cnt <= s_cnt + 4'd1;

      if (clr_cnt)    bit_idx <= '0;
      else if (shift) bit_idx <= bit_idx + 3'd1;

      if (shift) shreg <= {bit_val, shreg[7:1]};

      if (load) data <= shreg;

      if (load)                valid <= 1'b1;
      else if (valid && ready) valid <= 1'b0;

      frame_err <= fe_set;
      overrun   <= ovr_set;
      busy      <= (state_n != IDLE);
    end
  end

endmodule
